wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic initiator. Converts valid/ready single-transfer commands into one
//  Wishbone cycle and returns the result on a valid/ready response channel.
//  Sits on the bus-master side of register bridges and slave peripherals.
//  Enables CPU-less control paths (UART/JTAG debug bridges) to access the bus.
// PARAMETERS
//  DATA_WIDTH    32  data bus width in bits (8, 16, 32 or 64)
//  ADDR_WIDTH    32  address bus width in bits
//  SELECT_WIDTH  4   byte-select width, DATA_WIDTH/8
//  TIMEOUT       256 cycles in BUS before forced termination; 0 disables the timeout
//  MAX_RETRY     4   automatic re-issues on RTY; only used with WB_CMD_MASTER_RETRY_EN
// PORTS
//  m_clk       in   1             clock
//  s_rst       in   1             reset, synchronous, active-high
//  cmd_adr     in   ADDR_WIDTH    command address
//  cmd_dat     in   DATA_WIDTH    write data
//  cmd_we      in   1             1 = write, 0 = read
//  cmd_sel     in   SELECT_WIDTH  byte selects
//  cmd_valid   in   1             command valid
//  cmd_ready   out  1             command accepted when valid & ready
//  rsp_dat     out  DATA_WIDTH    read data; 0 for writes and failed reads
//  rsp_status  out  2             0 OK, 1 ERR, 2 RTY, 3 TIMEOUT
//  rsp_valid   out  1             response valid
//  rsp_ready   in   1             response consumed when valid & ready
//  wb_adr_o    out  ADDR_WIDTH    ADR_O
//  wb_dat_i    in   DATA_WIDTH    DAT_I
//  wb_dat_o    out  DATA_WIDTH    DAT_O
//  wb_we_o     out  1             WE_O
//  wb_sel_o    out  SELECT_WIDTH  SEL_O
//  wb_stb_o    out  1             STB_O
//  wb_ack_i    in   1             ACK_I
//  wb_err_i    in   1             ERR_I
//  wb_rty_i    in   1             RTY_I
//  wb_cyc_o    out  1             CYC_O
// BEHAVIOUR
//  - All outputs are registered except cmd_ready, which is (state == IDLE).
//  - Reset: every wb_* output is 0, rsp_dat/rsp_status/rsp_valid are 0, state is IDLE,
//    and the timeout and retry counters are 0.
//  - Reset asserted mid-cycle drops cyc/stb on the next edge; the pending command and
//    response are discarded.
//  - IDLE:
//    - On cmd_valid & cmd_ready, register adr/dat/we/sel onto wb_* and set cyc = stb = 1
//      on the same edge. cyc/stb are therefore visible 1 cycle after acceptance.
//    - State goes to BUS.
//  - BUS: cyc/stb and all wb_* outputs hold stable until termination. The timeout
//    counter increments every cycle.
//  - Termination occurs on ack | err | rty, or on counter == TIMEOUT-1 when TIMEOUT != 0.
//    - Priority when several are asserted together: err > rty > ack > timeout.
//    - On the terminating edge: cyc = stb = we = 0.
//    - rsp_dat = wb_dat_i only for a read with ack; otherwise 0.
//    - rsp_status is set per the encoding above; rsp_valid = 1; state goes to RESP.
//  - RESP: rsp_* hold stable while rsp_valid & ~rsp_ready. On rsp_ready: rsp_valid = 0,
//    state goes to IDLE.
//  - Minimum throughput is 1 transfer per 3 cycles. A zero-wait slave gives 2 cycles from
//    acceptance to rsp_valid.
//  - Terminations outside BUS are ignored. cyc_o never asserts without stb_o.
//  - The timeout counter is TIMEOUT-width clog2, saturates at its limit, and clears on
//    entering BUS.
// CONFIGURATION
//  WB_CMD_MASTER_RETRY_EN
//  - Defined, rty with retry_cnt < MAX_RETRY:
//    - Go to GAP: cyc = stb = 0 for exactly 1 cycle.
//    - Re-issue the identical cycle; retry_cnt increments; the timeout counter restarts.
//  - Defined, rty with retry_cnt == MAX_RETRY: respond with status 2.
//  - Defined: retry_cnt clears on acceptance. err and timeout are never retried.
//  - Not defined: rty terminates immediately with status 2. There is no GAP state and
//    MAX_RETRY is unused.
// STRUCTURE
//  - Package wb_pkg holds:
//    - status localparams WB_RSP_OK/ERR/RTY/TIMEOUT;
//    - state encoding IDLE/BUS/GAP/RESP.
//  - Single module, no sub-modules. The timeout counter is inline; it is too small to
//    split out.
// TESTING
//  1. Write 0xDEADBEEF to 0x100, sel 0xF, slave acks after 3 waits ->
//     wb_dat_o = 0xDEADBEEF, we = 1 for 4 cycles; rsp_status 0, rsp_dat 0.
//  2. Read 0x104, slave returns 0x12345678 with ack ->
//     rsp_dat 0x12345678, status 0; cyc low the cycle after ack.
//  3. Slave asserts err and ack together on a read ->
//     status 1, rsp_dat 0.
//  4. TIMEOUT = 16, slave never responds ->
//     cyc drops after exactly 16 BUS cycles; status 3.
//  5. RETRY_EN, MAX_RETRY = 2, slave rty twice then ack ->
//     3 cyc pulses, each separated by 1 low cycle; status 0.
//     Same with rty x3 -> status 2.
//  6. s_rst asserted during BUS with rsp_ready held low ->
//     cyc/stb 0 next edge, rsp_valid stays 0; next command runs normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: response status codes
// and the controller state encoding.
package wb_pkg;

  localparam logic [1:0] WB_RSP_OK      = 2'd0;
  localparam logic [1:0] WB_RSP_ERR     = 2'd1;
  localparam logic [1:0] WB_RSP_RTY     = 2'd2;
  localparam logic [1:0] WB_RSP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle,
// the result returns on a valid/ready response. Optional WB_CMD_MASTER_RETRY_EN.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT      = 256,
  parameter int MAX_RETRY    = 4
) (
  input  logic                    m_clk,
  input  logic                    s_rst,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic [1:0]              rsp_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic                    wb_cyc_o
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LIM = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  wb_state_e r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0]   r_adr, w_adr_nxt;
  logic [DATA_WIDTH-1:0]   r_dat, w_dat_nxt;
  logic                    r_we, w_we_nxt;
  logic [SELECT_WIDTH-1:0] r_sel, w_sel_nxt;
  logic                    r_cyc, w_cyc_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_dat, w_rsp_dat_nxt;
  logic [1:0]              r_rsp_status, w_rsp_status_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [TO_W-1:0]         r_to_cnt, w_to_cnt_nxt;

  logic                    w_timeout;
  logic                    w_term;
  logic [1:0]              w_term_status;

`ifdef WB_CMD_MASTER_RETRY_EN
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RT_W-1:0] r_retry_cnt, w_retry_cnt_nxt;
`endif

  assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == TO_LIM);

  always_ff @(posedge m_clk) begin
    if (s_rst) begin
      r_state      <= IDLE;
      r_adr        <= '0;
      r_dat        <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_cyc        <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= WB_RSP_OK;
      r_rsp_valid  <= 1'b0;
      r_to_cnt     <= '0;
`ifdef WB_CMD_MASTER_RETRY_EN
      r_retry_cnt  <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_adr        <= w_adr_nxt;
      r_dat        <= w_dat_nxt;
      r_we         <= w_we_nxt;
      r_sel        <= w_sel_nxt;
      r_cyc        <= w_cyc_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
`ifdef WB_CMD_MASTER_RETRY_EN
      r_retry_cnt  <= w_retry_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_adr_nxt        = r_adr;
    w_dat_nxt        = r_dat;
    w_we_nxt         = r_we;
    w_sel_nxt        = r_sel;
    w_cyc_nxt        = r_cyc;
    w_rsp_dat_nxt    = r_rsp_dat;
    w_rsp_status_nxt = r_rsp_status;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_to_cnt_nxt     = r_to_cnt;
    w_term           = 1'b0;
    w_term_status    = WB_RSP_OK;
`ifdef WB_CMD_MASTER_RETRY_EN
    w_retry_cnt_nxt  = r_retry_cnt;
`endif

    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_adr_nxt    = cmd_adr;
          w_dat_nxt    = cmd_dat;
          w_we_nxt     = cmd_we;
          w_sel_nxt    = cmd_sel;
          w_cyc_nxt    = 1'b1;
          w_to_cnt_nxt = '0;
`ifdef WB_CMD_MASTER_RETRY_EN
          w_retry_cnt_nxt = '0;
`endif
          w_state_nxt  = BUS;
        end
      end
      BUS: begin
        if (r_to_cnt != TO_LIM) w_to_cnt_nxt = r_to_cnt + 1'b1;
        // err > rty > ack > timeout
        if (wb_err_i) begin
          w_term        = 1'b1;
          w_term_status = WB_RSP_ERR;
        end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
          if (r_retry_cnt < RT_W'(MAX_RETRY)) begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = GAP;
          end else begin
            w_term        = 1'b1;
            w_term_status = WB_RSP_RTY;
          end
`else
          w_term        = 1'b1;
          w_term_status = WB_RSP_RTY;
`endif
        end else if (wb_ack_i) begin
          w_term        = 1'b1;
          w_term_status = WB_RSP_OK;
        end else if (w_timeout) begin
          w_term        = 1'b1;
          w_term_status = WB_RSP_TIMEOUT;
        end
      end
`ifdef WB_CMD_MASTER_RETRY_EN
      GAP: begin
        // bus held idle for exactly one cycle, then the same cycle is re-issued
        w_cyc_nxt       = 1'b1;
        w_to_cnt_nxt    = '0;
        w_retry_cnt_nxt = r_retry_cnt + 1'b1;
        w_state_nxt     = BUS;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_term) begin
      w_cyc_nxt        = 1'b0;
      w_we_nxt         = 1'b0;
      w_rsp_status_nxt = w_term_status;
      w_rsp_dat_nxt    = (w_term_status == WB_RSP_OK && !r_we) ? wb_dat_i : '0;
      w_rsp_valid_nxt  = 1'b1;
      w_state_nxt      = RESP;
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_we_o    = r_we;
  assign wb_sel_o   = r_sel;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;
  assign rsp_dat    = r_rsp_dat;
  assign rsp_status = r_rsp_status;
  assign rsp_valid  = r_rsp_valid;

endmodule
